// File: rtl/fibo_gen.sv
// Streams consecutive Fibonacci terms over a valid/ready port on request.
// Terms wrap to 0 once the next value no longer fits in WIDTH bits.
module fibo_gen #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] MAX_TERM = {1'b0, {WIDTH{1'b1}}};

    state_t           state, state_nxt;
    logic [WIDTH:0]   a, a_nxt;
    logic [WIDTH:0]   b, b_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= {{WIDTH{1'b0}}, 1'b1};
            rem   <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            rem   <= rem_nxt;
        end
    end

    // Handshake: a term moves when out_valid & out_ready are both high at a
    // rising edge; out/out_last are stable while out_valid waits for ready.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = '0;
                    b_nxt     = {{WIDTH{1'b0}}, 1'b1};
                    rem_nxt   = len;
                    state_nxt = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    rem_nxt = rem - 1'b1;
                    // The final term is left in a so out holds it while idle.
                    if (rem == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_nxt = FIN;
                    end else if (b > MAX_TERM) begin
                        a_nxt = '0;
                        b_nxt = {{WIDTH{1'b0}}, 1'b1};
                    end else begin
                        a_nxt = b;
                        b_nxt = a + b;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out       = a[WIDTH-1:0];
    assign out_valid = (state == RUN);
    assign out_last  = (state == RUN) && (rem == {{(LEN_W-1){1'b0}}, 1'b1});
    assign busy      = (state == RUN);
    assign done      = (state == FIN);
    assign state_dbg = state;

endmodule

// File: tb/tb_fibo_gen.sv
// Randomized bench for fibo_gen: expected terms come from a plain Fibonacci
// model with wrap, queued per request and popped on each transfer.
module tb_fibo_gen;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
    localparam int MAX_TERM = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    int tests_run;
    int tests_failed;
    logic [WIDTH-1:0] exp_q[$];

    fibo_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // k-th term (0-based) of the sequence, restarting at 0 after the largest fitting term
    function automatic int fib_term(input int k);
        int x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < k; i++) begin
            if (y > MAX_TERM) begin
                x = 0;
                y = 1;
            end else begin
                t = x + y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    // reference membership detector
    function automatic logic is_fib(input int v);
        int x, y, t;
        x = 0;
        y = 1;
        while (x <= MAX_TERM) begin
            if (x == v) return 1'b1;
            t = x + y;
            x = y;
            y = t;
        end
        return 1'b0;
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1,0,1,1 then ready.
    // inject_at >= 0 pulses start (len=2) while presenting that term index.
    task automatic run_req(input int n, input int ready_mode, input int inject_at);
        logic [6:0] pat;
        int sent;
        int cyc;
        logic [WIDTH-1:0] last_term;
        pat = 7'b1101001;
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("len0_done", done, 1);
            check("len0_valid", out_valid, 0);
            check("len0_busy", busy, 0);
            @(negedge clk);
            check("len0_done_clr", done, 0);
            check("len0_valid_clr", out_valid, 0);
            return;
        end
        for (int k = 0; k < n; k++) exp_q.push_back(WIDTH'(fib_term(k)));
        sent = 0;
        cyc  = 0;
        last_term = '0;
        while (exp_q.size() > 0) begin
            if (cyc > 1000) begin
                check("timeout", 1, 0);
                exp_q.delete();
                return;
            end
            check("valid", out_valid, 1);
            check("busy", busy, 1);
            check("done_low", done, 0);
            check("term", out, exp_q[0]);
            check("last", out_last, (exp_q.size() == 1) ? 1 : 0);
            check("is_fib", is_fib(int'(out)), 1);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 60);
                default: out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
            endcase
            start = (sent == inject_at);
            len   = LEN_W'(2);
            @(posedge clk);
            if (out_ready) begin
                last_term = exp_q.pop_front();
                sent++;
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        out_ready = 1'b1;
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_valid", out_valid, 0);
        check("sent_count", sent, n);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
        check("out_held", out, last_term);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;

        run_req(8, 0, -1);    // 0..13, last on 13
        run_req(12, 0, -1);   // wraps after 13
        run_req(4, 2, -1);    // stalls
        run_req(0, 0, -1);    // empty request
        run_req(5, 0, 2);     // start ignored mid-sequence

        // reset after the 3rd term of an 8-term request
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 0);
        run_req(3, 0, -1);

        for (int r = 0; r < 12; r++) begin
            run_req($urandom_range(0, 20), 1, ($urandom_range(0, 3) == 0) ? 1 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
